button_debounce_pulse: RTL
==========================

// Module: button_debounce_pulse
// PURPOSE
// - Front end for the board push-buttons: synchronises each raw key pin to clk, debounces it,
//   and emits clean level plus single-cycle press/release pulses.
// - Sits directly upstream of the game-option selector; press_pulse[0] is its advance request,
//   so one physical press moves the selector exactly one step.
// PARAMETERS
// - NUM_BUTTONS      4        number of independent key channels
// - DEBOUNCE_CYCLES  500000   consecutive stable cycles required to accept a change (>=1; 10 ms @ 50 MHz)
// - ACTIVE_LOW       1        1: pin low = pressed (board keys); 0: pin high = pressed
// - REPEAT_DELAY     25000000 cycles held before first auto-repeat pulse (used only with macro)
// - REPEAT_PERIOD    10000000 cycles between subsequent auto-repeat pulses (used only with macro)
// PORTS
// - clk            in   1            system clock, all state on rising edge
// - rst_n          in   1            asynchronous active-low reset
// - btn_raw        in   NUM_BUTTONS  raw asynchronous key pins
// - btn_level      out  NUM_BUTTONS  debounced state, 1 = pressed (polarity normalised)
// - press_pulse    out  NUM_BUTTONS  1-cycle strobe on accepted press (and auto-repeat)
// - release_pulse  out  NUM_BUTTONS  1-cycle strobe on accepted release
// BEHAVIOUR
// - Reset (rst_n low, async): sync flops = released level, btn_level=0, press_pulse=0,
//   release_pulse=0, all counters=0. Reset mid-bounce or mid-hold discards the event; no pulse on exit.
// - Per channel: 2-FF synchroniser, then normalise polarity (invert when ACTIVE_LOW=1) -> s.
// - Counter cnt, width $clog2(DEBOUNCE_CYCLES+1): if s==btn_level, cnt<=0; else cnt<=cnt+1;
//   when s!=btn_level and cnt==DEBOUNCE_CYCLES-1: btn_level<=s, cnt<=0.
// - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles resets cnt; level unchanged, no pulse.
// - Latency: pin settled before edge k -> btn_level changes at edge k+1+DEBOUNCE_CYCLES
//   (2 sync edges, then DEBOUNCE_CYCLES counting edges, counted from edge k as first sync edge).
// - press_pulse/release_pulse registered: asserted on the same edge btn_level rises/falls,
//   deasserted on the next edge. Exactly one pulse per accepted transition; never both at once.
// - Channels fully independent; simultaneous presses on several keys yield simultaneous pulses.
// - Counter saturates by construction (cleared at terminal count); no wrap-around.
// CONFIGURATION
// - Macro BUTTON_AUTOREPEAT_EN defined: per-channel hold counter (width $clog2(max(REPEAT_DELAY,
//   REPEAT_PERIOD)+1)), cleared when btn_level=0; while held, extra press_pulse at REPEAT_DELAY
//   cycles after the accepted press, then every REPEAT_PERIOD cycles until release.
//   Release stops repeats immediately; release_pulse unchanged.
// - Macro undefined: no hold counter synthesised, REPEAT_* ignored, one press_pulse per press.
// STRUCTURE
// - Package button_pkg: DEBOUNCE_CYCLES_DEFAULT, REPEAT_*_DEFAULT, NUM_BUTTONS_DEFAULT constants,
//   and enum typedef for key indices (KEY_GAME_CHANGE=0, KEY_CONFIRM=1, ...).
// - Sub-module debounce_channel: one synchroniser + counter + pulse (+ repeat) for a single key;
//   top instantiates NUM_BUTTONS copies in a generate loop.
// TESTING (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, ACTIVE_LOW=1)
// - Clean press: btn_raw[0] 1->0 held 20 cycles -> btn_level[0]=1 and press_pulse[0]=1 for exactly
//   one cycle, 6 edges after the pin change; other channels stay 0.
// - Bounce: btn_raw[0] toggles with 2-cycle low runs for 30 cycles -> no pulse; then stable low ->
//   exactly one press_pulse[0].
// - Release: from pressed, pin 0->1 held -> release_pulse[0] one cycle, btn_level[0]=0, no press_pulse.
// - Simultaneous: btn_raw=4'b0000 from all-released -> press_pulse=4'b1111 in the same cycle.
// - Async reset mid-count: assert rst_n low 2 cycles after pin goes low -> outputs 0 at once;
//   after release of reset with pin still low, one press_pulse after full debounce latency.
// - BUTTON_AUTOREPEAT_EN: hold key 60 cycles past acceptance -> press_pulse at +0, +20, +28, +36,
//   +44, +52; without macro -> single pulse at +0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and key index names for the push-button front end.
// Contents:
//   *_DEFAULT constants : default parameter values for button_debounce_pulse
//   key_idx_e           : named key positions on the btn_* buses
//   max_int             : helper used to size the auto-repeat hold counter
// Optional feature macro elsewhere in this slice: BUTTON_AUTOREPEAT_EN.
package button_pkg;

  localparam int NUM_BUTTONS_DEFAULT     = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;    // 10 ms at 50 MHz
  localparam int REPEAT_DELAY_DEFAULT    = 25000000;  // 500 ms at 50 MHz
  localparam int REPEAT_PERIOD_DEFAULT   = 10000000;  // 200 ms at 50 MHz

  typedef enum logic [1:0] {
    KEY_GAME_CHANGE = 2'd0,
    KEY_CONFIRM     = 2'd1,
    KEY_BACK        = 2'd2,
    KEY_AUX         = 2'd3
  } key_idx_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single key channel: 2-FF synchroniser, polarity normalisation, debounce
// counter and registered press/release strobes.
// Ports:
//   clk           in  system clock
//   rst_n         in  asynchronous active-low reset
//   btn_raw       in  raw asynchronous key pin
//   btn_level     out debounced state, 1 = pressed
//   press_pulse   out 1-cycle strobe on accepted press (and auto-repeat)
//   release_pulse out 1-cycle strobe on accepted release
// Macro BUTTON_AUTOREPEAT_EN adds a hold counter that re-issues press_pulse
// REPEAT_DELAY cycles after the press and every REPEAT_PERIOD cycles after.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            RELEASED_PIN = ACTIVE_LOW;

  logic             sync1_q, sync2_q;
  logic             s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RELEASED_PIN;
      sync2_q <= RELEASED_PIN;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ ACTIVE_LOW;

  // Any sample equal to the current level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      level_d = s;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign release_d = accept & ~s;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [HOLD_W-1:0] DELAY_TC  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_TC = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              armed_q, armed_d;   // first repeat already issued
  logic              rep_fire;

  always_comb begin
    hold_d   = hold_q;
    armed_d  = armed_q;
    rep_fire = 1'b0;
    if (!level_q) begin
      hold_d  = '0;
      armed_d = 1'b0;
    end else if ((!armed_q && hold_q == DELAY_TC) || (armed_q && hold_q == PERIOD_TC)) begin
      // Suppressed on the release edge so press and release never coincide.
      rep_fire = level_d;
      hold_d   = '0;
      armed_d  = 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      armed_q <= armed_d;
    end
  end

  assign press_d = (accept & s) | rep_fire;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
  assign press_d = accept & s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Push-button front end: NUM_BUTTONS independent debounce channels.
// press_pulse[KEY_GAME_CHANGE] drives the game-option selector advance.
// Ports:
//   clk           in  system clock
//   rst_n         in  asynchronous active-low reset
//   btn_raw       in  [NUM_BUTTONS] raw asynchronous key pins
//   btn_level     out [NUM_BUTTONS] debounced state, 1 = pressed
//   press_pulse   out [NUM_BUTTONS] 1-cycle strobe on accepted press (and auto-repeat)
//   release_pulse out [NUM_BUTTONS] 1-cycle strobe on accepted release
// Macro BUTTON_AUTOREPEAT_EN enables per-channel auto-repeat (see debounce_channel).
module button_debounce_pulse
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = NUM_BUTTONS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_raw      (btn_raw[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule
